// File: rtl/btle_pkg.sv
// Shared BLE TX definitions: CRC24 polynomial, header lengths, frame states
// and the one-bit CRC24 LFSR step.
package btle_pkg;

  localparam int unsigned CRC_W              = 24;
  localparam int unsigned APP_CNT_W          = 5;
  localparam logic [23:0] CRC24_TAPS         = 24'h00065B;
  localparam int unsigned BLE_HEADER_BITS_1M = 40;
  localparam int unsigned BLE_HEADER_BITS_2M = 48;
  localparam logic [23:0] CRC_INIT_ADV       = 24'h555555;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    PDU    = 2'd2,
    APPEND = 2'd3
  } crc_state_e;

  // r[0] takes the feedback; tapped positions above bit 0 xor it in.
  function automatic logic [23:0] crc24_step(input logic [23:0] r, input logic d);
    logic fb;
    fb = r[23] ^ d;
    crc24_step = {r[22:0], fb} ^ ({24{fb}} & {CRC24_TAPS[23:1], 1'b0});
  endfunction

endpackage

// File: rtl/crc24_lfsr_core.sv
// 24-bit CRC LFSR with load (highest priority), per-bit update and
// MSB-first shift-out.
module crc24_lfsr_core
  import btle_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CRC_W-1:0] init_i,
  input  logic             upd_i,
  input  logic             bit_i,
  input  logic             shift_i,
  output logic             msb_o
);

  logic [CRC_W-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    if (load_i) begin
      r_d = init_i;
    end else if (upd_i) begin
      r_d = crc24_step(r_q, bit_i);
    end else if (shift_i) begin
      r_d = {r_q[CRC_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign msb_o = r_q[CRC_W-1];

endmodule

// File: rtl/crc24_append.sv
// BLE TX bit-serial CRC24 appender: passes header and PDU bits through with
// one cycle of latency, then emits the 24 CRC bits MSB-first with last on the final one.
module crc24_append
  import btle_pkg::*;
#(
  parameter int unsigned HEADER_BITS = BLE_HEADER_BITS_1M,
  parameter int unsigned COUNT_WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CRC_W-1:0] crc_state_init_bit,
  input  logic             crc_state_init_load,
  input  logic             data_in,
  input  logic             data_in_valid,
  input  logic             data_in_valid_last,
  output logic             data_in_ready,
  output logic             data_out,
  output logic             data_out_valid,
  output logic             data_out_valid_last
);

  crc_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [APP_CNT_W-1:0]   app_q, app_d;
  logic                   dout_q, dout_d;
  logic                   vld_q, vld_d;
  logic                   last_q, last_d;
  logic                   accept;
  logic                   in_pdu;
  logic                   hdr_done;
  logic                   lfsr_upd;
  logic                   lfsr_shift;
  logic                   crc_msb;

  assign data_in_ready = (state_q != APPEND);
  assign accept        = data_in_valid & data_in_ready;
  assign in_pdu        = (cnt_q >= COUNT_WIDTH'(HEADER_BITS));
  assign hdr_done      = ((cnt_q + COUNT_WIDTH'(1)) >= COUNT_WIDTH'(HEADER_BITS));

  crc24_lfsr_core u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (crc_state_init_load),
    .init_i  (crc_state_init_bit),
    .upd_i   (lfsr_upd),
    .bit_i   (data_in),
    .shift_i (lfsr_shift),
    .msb_o   (crc_msb)
  );

  // APPEND stays one cycle past the final CRC bit so ready returns after it is visible.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    app_d      = app_q;
    dout_d     = 1'b0;
    vld_d      = 1'b0;
    last_d     = 1'b0;
    lfsr_upd   = 1'b0;
    lfsr_shift = 1'b0;
    case (state_q)
      IDLE, HEADER, PDU: begin
        if (accept) begin
          cnt_d    = cnt_q + COUNT_WIDTH'(1);
          dout_d   = data_in;
          vld_d    = 1'b1;
          lfsr_upd = in_pdu;
          if (data_in_valid_last) begin
            state_d = APPEND;
          end else if (hdr_done) begin
            state_d = PDU;
          end else begin
            state_d = HEADER;
          end
        end
      end
      APPEND: begin
        if (last_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          app_d   = '0;
        end else begin
          lfsr_shift = 1'b1;
          dout_d     = crc_msb;
          vld_d      = 1'b1;
          last_d     = (app_q == APP_CNT_W'(CRC_W - 1));
          app_d      = app_q + APP_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      app_q   <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      app_q   <= app_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign data_out            = dout_q;
  assign data_out_valid      = vld_q;
  assign data_out_valid_last = last_q;

endmodule

// File: tb/tb_crc24_append.sv
// Self-checking bench for crc24_append: directed and randomized frames
// compared against a bit-serial CRC24 reference model.
module tb_crc24_append;

  logic        clk;
  logic        rst;
  logic [23:0] crc_state_init_bit;
  logic        crc_state_init_load;
  logic        data_in;
  logic        data_in_valid;
  logic        data_in_valid_last;
  logic        data_in_ready;
  logic        data_out;
  logic        data_out_valid;
  logic        data_out_valid_last;

  int n_vec;
  int n_err;
  bit hdr_q[$];
  bit pdu_q[$];
  int outs;

  crc24_append dut (
    .clk                 (clk),
    .rst                 (rst),
    .crc_state_init_bit  (crc_state_init_bit),
    .crc_state_init_load (crc_state_init_load),
    .data_in             (data_in),
    .data_in_valid       (data_in_valid),
    .data_in_valid_last  (data_in_valid_last),
    .data_in_ready       (data_in_ready),
    .data_out            (data_out),
    .data_out_valid      (data_out_valid),
    .data_out_valid_last (data_out_valid_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Polynomial-division form of the CRC over the PDU bits only.
  function automatic logic [23:0] ref_crc(input logic [23:0] init);
    logic [23:0] c;
    logic        fb;
    c = init;
    foreach (pdu_q[i]) begin
      fb = c[23] ^ pdu_q[i];
      c  = (c << 1) ^ (fb ? 24'h00065B : 24'h000000);
    end
    return c;
  endfunction

  task automatic drive_cycle(input logic v, input logic d, input logic l);
    data_in_valid      = v;
    data_in            = d;
    data_in_valid_last = l;
    @(posedge clk);
    #1;
    data_in_valid      = 1'b0;
    data_in_valid_last = 1'b0;
  endtask

  task automatic load_init(input logic [23:0] init);
    crc_state_init_bit  = init;
    crc_state_init_load = 1'b1;
    @(posedge clk);
    #1;
    crc_state_init_load = 1'b0;
    chk("load_vld", data_out_valid, 1'b0);
    chk("load_rdy", data_in_ready, 1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit to_pdu);
    for (int i = 0; i < 8; i++) begin
      if (to_pdu) pdu_q.push_back(b[i]);
      else        hdr_q.push_back(b[i]);
    end
  endtask

  task automatic ble_header();
    logic [31:0] aa;
    aa = 32'h8E89BED6;
    hdr_q.delete();
    push_byte(8'hAA, 1'b0);
    for (int i = 0; i < 4; i++) push_byte(aa[8*i +: 8], 1'b0);
  endtask

  task automatic rand_header();
    hdr_q.delete();
    for (int i = 0; i < 40; i++) hdr_q.push_back(1'($urandom_range(1)));
  endtask

  // Streams header+PDU, then checks the 24 CRC bits, last and ready timing.
  task automatic run_frame(input logic [23:0] init, input bit do_load, input int gap_pct, input bit junk);
    logic [23:0] crc;
    int          hn;
    int          total;
    logic        b;
    if (do_load) load_init(init);
    crc   = ref_crc(init);
    hn    = hdr_q.size();
    total = hn + pdu_q.size();
    outs  = 0;
    for (int i = 0; i < total; i++) begin
      b = (i < hn) ? hdr_q[i] : pdu_q[i - hn];
      while (int'($urandom_range(99)) < gap_pct) begin
        drive_cycle(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
        chk("gap_vld", data_out_valid, 1'b0);
        chk("gap_rdy", data_in_ready, 1'b1);
      end
      drive_cycle(1'b1, b, (i == total - 1));
      chk("pass_vld", data_out_valid, 1'b1);
      chk("pass_dat", data_out, b);
      chk("pass_last", data_out_valid_last, 1'b0);
      outs++;
    end
    chk("app_rdy0", data_in_ready, 1'b0);
    for (int k = 0; k < 24; k++) begin
      drive_cycle(junk ? 1'($urandom_range(1)) : 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)));
      chk("crc_vld", data_out_valid, 1'b1);
      chk("crc_dat", data_out, crc[23-k]);
      chk("crc_last", data_out_valid_last, (k == 23));
      chk("crc_rdy", data_in_ready, 1'b0);
      outs++;
    end
    drive_cycle(junk, 1'($urandom_range(1)), 1'b0);
    chk("end_vld", data_out_valid, 1'b0);
    chk("end_last", data_out_valid_last, 1'b0);
    chk("end_rdy", data_in_ready, 1'b1);
  endtask

  task automatic rand_pdu(input int nbytes);
    pdu_q.delete();
    for (int i = 0; i < nbytes; i++) push_byte(8'($urandom_range(255)), 1'b1);
  endtask

  initial begin
    n_vec               = 0;
    n_err               = 0;
    rst                 = 1'b0;
    crc_state_init_bit  = '0;
    crc_state_init_load = 1'b0;
    data_in             = 1'b0;
    data_in_valid       = 1'b0;
    data_in_valid_last  = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_dat", data_out, 1'b0);
    chk("rst_vld", data_out_valid, 1'b0);
    chk("rst_last", data_out_valid_last, 1'b0);
    chk("rst_rdy", data_in_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reference header, single '0' PDU bit: CRC equals the tap mask.
    ble_header();
    pdu_q.delete();
    pdu_q.push_back(1'b0);
    run_frame(24'h800000, 1'b1, 0, 1'b0);

    // init=1, single '0' bit, inputs driven during the append phase.
    rand_header();
    run_frame(24'h000001, 1'b1, 0, 1'b1);

    // Back-to-back frame without reload: LFSR was shifted out to zero.
    rand_header();
    pdu_q.delete();
    for (int i = 0; i < 16; i++) pdu_q.push_back(1'b0);
    run_frame(24'h000000, 1'b0, 0, 1'b0);
    chk("stream_len", 32'(outs), 32'd80);

    // Last on the final header bit: CRC is the init value itself.
    rand_header();
    pdu_q.delete();
    run_frame(24'h123456, 1'b1, 20, 1'b1);

    // Randomized advertising frames; a stale load precedes the real one.
    for (int f = 0; f < 4; f++) begin
      load_init(24'($urandom));
      ble_header();
      rand_pdu(int'($urandom_range(257, 2)));
      run_frame(24'h555555, 1'b1, 30, 1'b1);
    end

    // Reset mid-PDU, then a clean frame from the reset LFSR and one loaded frame.
    load_init(24'h555555);
    ble_header();
    for (int i = 0; i < 40; i++) drive_cycle(1'b1, hdr_q[i], 1'b0);
    for (int i = 0; i < 19; i++) drive_cycle(1'b1, 1'($urandom_range(1)), 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    chk("pre_rst_dat", data_out, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dat", data_out, 1'b0);
    chk("mid_rst_vld", data_out_valid, 1'b0);
    chk("mid_rst_last", data_out_valid_last, 1'b0);
    chk("mid_rst_rdy", data_in_ready, 1'b1);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    rand_header();
    rand_pdu(3);
    run_frame(24'h000000, 1'b0, 10, 1'b0);
    ble_header();
    rand_pdu(int'($urandom_range(12, 2)));
    run_frame(24'h555555, 1'b1, 25, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
